// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_scheduler
//  Description : Round-robin write-port scheduler (ALU / LSU writeback) and
//                destination-register scoreboard with RAW/WAW issue stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_issue_valid,
    input  logic                         i_issue_has_rd,
    input  logic [ADDR_WIDTH-1:0]        i_issue_rd,
    input  logic [ADDR_WIDTH-1:0]        i_issue_rs1,
    input  logic [ADDR_WIDTH-1:0]        i_issue_rs2,
    output logic                         o_issue_stall,
    input  logic                         i_alu_valid,
    input  logic [ADDR_WIDTH-1:0]        i_alu_rd,
    input  logic [DATA_WIDTH-1:0]        i_alu_data,
    output logic                         o_alu_ready,
    input  logic                         i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0]        i_lsu_rd,
    input  logic [DATA_WIDTH-1:0]        i_lsu_data,
    output logic                         o_lsu_ready,
    output logic                         o_rf_we,
    output logic [ADDR_WIDTH-1:0]        o_rf_waddr,
    output logic [DATA_WIDTH-1:0]        o_rf_wdata,
    output logic [(2**ADDR_WIDTH)-1:0]   o_pending
);

    localparam int c_num_regs = 2**ADDR_WIDTH;

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_t;

    ptr_t                    r_ptr;
    logic                    r_rf_we;
    logic [ADDR_WIDTH-1:0]   r_rf_waddr;
    logic [DATA_WIDTH-1:0]   r_rf_wdata;
    logic [c_num_regs-1:0]   r_pending;

    logic                    w_conflict;
    logic                    w_alu_grant;
    logic                    w_lsu_grant;
    logic                    w_xfer;
    logic [ADDR_WIDTH-1:0]   w_xfer_rd;
    logic [DATA_WIDTH-1:0]   w_xfer_data;
    logic                    w_issue_fire;
    logic [c_num_regs-1:0]   w_pending_next;

    // A sole requester always wins; the pointer only decides conflicts.
    assign w_conflict  = i_alu_valid & i_lsu_valid;
    assign w_alu_grant = i_alu_valid & (~i_lsu_valid | (r_ptr == PTR_ALU));
    assign w_lsu_grant = i_lsu_valid & (~i_alu_valid | (r_ptr == PTR_LSU));
    assign w_xfer      = w_alu_grant | w_lsu_grant;
    assign w_xfer_rd   = w_lsu_grant ? i_lsu_rd   : i_alu_rd;
    assign w_xfer_data = w_lsu_grant ? i_lsu_data : i_alu_data;

    assign o_alu_ready = w_alu_grant;
    assign o_lsu_ready = w_lsu_grant;

    // No bypass: stall is driven purely from the registered scoreboard.
    assign o_issue_stall = i_issue_valid &
                           (r_pending[i_issue_rs1] |
                            r_pending[i_issue_rs2] |
                            (i_issue_has_rd & r_pending[i_issue_rd]));

    assign w_issue_fire = i_issue_valid & ~o_issue_stall & i_issue_has_rd &
                          (i_issue_rd != '0);

    // Clear is applied before set so a same-edge set wins.
    always_comb begin
        w_pending_next = r_pending;
        if (r_rf_we) begin
            w_pending_next[r_rf_waddr] = 1'b0;
        end
        if (w_issue_fire) begin
            w_pending_next[i_issue_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= PTR_LSU;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pending  <= '0;
        end else begin
            if (w_conflict) begin
                r_ptr <= w_lsu_grant ? PTR_ALU : PTR_LSU;
            end
            // x0 transfers are consumed but never reach the register file.
            r_rf_we <= w_xfer & (w_xfer_rd != '0);
            if (w_xfer && (w_xfer_rd != '0)) begin
                r_rf_waddr <= w_xfer_rd;
                r_rf_wdata <= w_xfer_data;
            end
            r_pending <= w_pending_next;
        end
    end

    assign o_rf_we    = r_rf_we;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_scheduler
//  Description : Directed + random bench for regfile_wb_scheduler against a
//                behavioural scoreboard/arbiter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_issue_valid, i_issue_has_rd;
    logic [AW-1:0] i_issue_rd, i_issue_rs1, i_issue_rs2;
    logic          o_issue_stall;
    logic          i_alu_valid;
    logic [AW-1:0] i_alu_rd;
    logic [DW-1:0] i_alu_data;
    logic          o_alu_ready;
    logic          i_lsu_valid;
    logic [AW-1:0] i_lsu_rd;
    logic [DW-1:0] i_lsu_data;
    logic          o_lsu_ready;
    logic          o_rf_we;
    logic [AW-1:0] o_rf_waddr;
    logic [DW-1:0] o_rf_wdata;
    logic [NR-1:0] o_pending;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_issue_valid(i_issue_valid), .i_issue_has_rd(i_issue_has_rd),
        .i_issue_rd(i_issue_rd), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
        .o_issue_stall(o_issue_stall),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .o_alu_ready(o_alu_ready),
        .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
        .o_lsu_ready(o_lsu_ready),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_pending(o_pending)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state: who wins the next conflict, outstanding writes,
    // and the write the register file should see after the next edge.
    bit          m_lsu_next;
    bit [NR-1:0] m_pend;
    bit          m_we;
    bit [AW-1:0] m_waddr;
    bit [DW-1:0] m_wdata;
    bit          alu_acc, lsu_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lsu_next = 1'b1;
        m_pend     = '0;
        m_we       = 1'b0;
        m_waddr    = '0;
        m_wdata    = '0;
    endtask

    function automatic void model_comb(output bit ag, output bit lg, output bit st);
        ag = 1'b0;
        lg = 1'b0;
        if (i_alu_valid && i_lsu_valid) begin
            if (m_lsu_next) lg = 1'b1;
            else            ag = 1'b1;
        end else if (i_alu_valid) begin
            ag = 1'b1;
        end else if (i_lsu_valid) begin
            lg = 1'b1;
        end
        st = 1'b0;
        if (i_issue_valid) begin
            if (m_pend[i_issue_rs1] || m_pend[i_issue_rs2]) st = 1'b1;
            if (i_issue_has_rd && m_pend[i_issue_rd])        st = 1'b1;
        end
    endfunction

    task automatic model_edge();
        bit ag, lg, st;
        model_comb(ag, lg, st);
        if (m_we) m_pend[m_waddr] = 1'b0;
        if (i_issue_valid && !st && i_issue_has_rd && i_issue_rd != 0)
            m_pend[i_issue_rd] = 1'b1;
        if (i_alu_valid && i_lsu_valid) m_lsu_next = ag;
        m_we = 1'b0;
        if (ag && i_alu_rd != 0) begin
            m_we = 1'b1; m_waddr = i_alu_rd; m_wdata = i_alu_data;
        end
        if (lg && i_lsu_rd != 0) begin
            m_we = 1'b1; m_waddr = i_lsu_rd; m_wdata = i_lsu_data;
        end
    endtask

    // One clock: inputs already applied at the falling edge.
    task automatic cycle();
        bit ag, lg, st;
        #1;
        model_comb(ag, lg, st);
        check("alu_ready", o_alu_ready, ag);
        check("lsu_ready", o_lsu_ready, lg);
        check("issue_stall", o_issue_stall, st);
        alu_acc = ag;
        lsu_acc = lg;
        @(posedge clk);
        model_edge();
        #1;
        check("rf_we", o_rf_we, m_we);
        check("rf_waddr", o_rf_waddr, m_waddr);
        check("rf_wdata", o_rf_wdata, m_wdata);
        check("pending", o_pending, m_pend);
        @(negedge clk);
    endtask

    task automatic set_alu(input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        i_alu_valid = v; i_alu_rd = rd; i_alu_data = d;
    endtask

    task automatic set_lsu(input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        i_lsu_valid = v; i_lsu_rd = rd; i_lsu_data = d;
    endtask

    task automatic set_issue(input bit v, input bit has, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        i_issue_valid = v; i_issue_has_rd = has;
        i_issue_rd = rd; i_issue_rs1 = rs1; i_issue_rs2 = rs2;
    endtask

    initial begin
        bit [NR-1:0] pend_snap;
        rst = 1'b0;
        set_alu(0, 0, 0); set_lsu(0, 0, 0); set_issue(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check("rst_we", o_rf_we, 0);
        check("rst_waddr", o_rf_waddr, 0);
        check("rst_wdata", o_rf_wdata, 0);
        check("rst_pending", o_pending, 0);
        rst = 1'b1;

        // Idle
        cycle();
        check("idle_pending", o_pending, 0);

        // ALU alone
        set_alu(1, 5, 32'hDEADBEEF);
        #1 check("alu_alone_ready", o_alu_ready, 1);
        cycle();
        check("alu_alone_we", o_rf_we, 1);
        check("alu_alone_waddr", o_rf_waddr, 5);
        check("alu_alone_wdata", o_rf_wdata, 32'hDEADBEEF);
        set_alu(0, 0, 0);

        // Three conflicts: LSU, ALU, LSU
        set_alu(1, 3, 32'hA3); set_lsu(1, 4, 32'hB4);
        cycle();
        check("conf0_waddr", o_rf_waddr, 4);
        set_lsu(1, 6, 32'hB6);
        cycle();
        check("conf1_waddr", o_rf_waddr, 3);
        set_alu(1, 8, 32'hA8);
        cycle();
        check("conf2_waddr", o_rf_waddr, 6);
        set_lsu(0, 0, 0);
        cycle();
        check("conf_tail_waddr", o_rf_waddr, 8);
        set_alu(0, 0, 0);

        // RAW on x7
        set_issue(1, 1, 7, 0, 0);
        cycle();
        check("raw_pend7", o_pending[7], 1);
        set_issue(1, 0, 0, 7, 0);
        #1 check("raw_stall", o_issue_stall, 1);
        cycle();
        cycle();
        set_alu(1, 7, 32'h77);
        cycle();
        set_alu(0, 0, 0);
        check("raw_we7", o_rf_waddr, 7);
        check("raw_stall_on_we", o_issue_stall, 1);
        cycle();
        check("raw_stall_drop", o_issue_stall, 0);
        set_issue(0, 0, 0, 0, 0);

        // WAW on x9, x0 never stalls
        set_issue(1, 1, 9, 0, 0);
        cycle();
        set_issue(1, 1, 9, 1, 2);
        #1 check("waw_stall", o_issue_stall, 1);
        set_issue(1, 1, 0, 0, 0);
        #1 check("x0_no_stall", o_issue_stall, 0);
        set_issue(1, 1, 9, 1, 2);
        set_lsu(1, 9, 32'h99);
        cycle();
        set_lsu(0, 0, 0);
        cycle();
        check("waw_stall_drop", o_issue_stall, 0);
        set_issue(0, 0, 0, 0, 0);
        cycle();

        // x0 writeback
        pend_snap = m_pend;
        set_lsu(1, 0, 32'h1234);
        #1 check("x0_lsu_ready", o_lsu_ready, 1);
        cycle();
        set_lsu(0, 0, 0);
        check("x0_we", o_rf_we, 0);
        check("x0_pending", o_pending, pend_snap);

        // Asynchronous reset in the middle of a transfer
        set_alu(1, 10, 32'hCAFE0010);
        set_issue(1, 1, 11, 0, 0);
        @(posedge clk);
        #2;
        check("mid_we_before", o_rf_we, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_we", o_rf_we, 0);
        check("mid_rst_waddr", o_rf_waddr, 0);
        check("mid_rst_wdata", o_rf_wdata, 0);
        check("mid_rst_pending", o_pending, 0);
        set_alu(0, 0, 0); set_issue(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cycle();
        check("post_rst_we", o_rf_we, 0);
        set_alu(1, 1, 32'h11); set_lsu(1, 2, 32'h22);
        cycle();
        check("post_rst_conf", o_rf_waddr, 2);
        set_lsu(0, 0, 0);
        cycle();
        set_alu(0, 0, 0);

        // Random traffic; losers hold their request, addresses kept small
        for (int n = 0; n < 600; n++) begin
            if (!(i_alu_valid && !alu_acc))
                set_alu($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom);
            if (!(i_lsu_valid && !lsu_acc))
                set_lsu($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom);
            set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Write-port scheduler and scoreboard for the two-read/one-write register file. Shares the single write port between the ALU writeback path and the load/store-unit writeback path using round-robin arbitration. Tracks destination registers with an outstanding write and stalls issue on RAW/WAW hazards. Sits between the issue stage, both writeback sources, and the register file write port.

Parameters:
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
i_issue_valid  input  1  issue stage presents an instruction
i_issue_has_rd  input  1  instruction writes a destination register
i_issue_rd  input  ADDR_WIDTH  destination register
i_issue_rs1  input  ADDR_WIDTH  source register 1
i_issue_rs2  input  ADDR_WIDTH  source register 2
o_issue_stall  output  1  hazard; issue must hold
i_alu_valid  input  1  ALU writeback request
i_alu_rd  input  ADDR_WIDTH  ALU writeback address
i_alu_data  input  DATA_WIDTH  ALU writeback data
o_alu_ready  output  1  ALU request accepted this cycle
i_lsu_valid  input  1  LSU writeback request
i_lsu_rd  input  ADDR_WIDTH  LSU writeback address
i_lsu_data  input  DATA_WIDTH  LSU writeback data
o_lsu_ready  output  1  LSU request accepted this cycle
o_rf_we  output  1  register file write enable
o_rf_waddr  output  ADDR_WIDTH  register file write address
o_rf_wdata  output  DATA_WIDTH  register file write data
o_pending  output  2**ADDR_WIDTH  scoreboard vector (debug)

Behaviour:
- Reset (rst low, async): o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, pending vector all 0, round-robin pointer = "LSU next". Reset mid-operation discards all in-flight state; no partial write is emitted after reset release.
- Arbitration is combinational from the valids and the registered pointer:
  - Only one valid: that source is granted (ready=1).
  - Both valid: the source named by the pointer wins; the loser's ready=0, and it must hold its valid/rd/data stable.
  - Pointer updates only on a conflict cycle, toggling to the loser, so the next conflict goes the other way. A sole-requester grant does not move the pointer.
  - Neither valid: both readys are 0.
- Handshake: a transfer occurs when valid and ready are both high. At most one transfer per cycle.
- Write port is registered, one cycle of latency:
  - The cycle after a transfer, o_rf_we=1, with o_rf_waddr/o_rf_wdata equal to the accepted rd/data.
  - Otherwise o_rf_we=0; o_rf_waddr/o_rf_wdata hold their last values.
- x0 writes: a transfer with rd=0 is accepted (ready asserted normally) but produces o_rf_we=0.
- Scoreboard, one bit per register; bit 0 is hardwired 0:
  - Set: on the clock edge where i_issue_valid=1, o_issue_stall=0, i_issue_has_rd=1 and i_issue_rd!=0.
  - Clear: on the clock edge where o_rf_we=1 for that address, i.e. the same edge the register file captures the data. A read issued in the following cycle sees the new value.
  - If set and clear for the same register fall on the same edge, set wins. This cannot occur for a legal issue, because WAW stalls it.
- o_issue_stall is combinational from the registered pending vector and is asserted only when i_issue_valid=1 and any of:
  - pending[rs1]
  - pending[rs2]
  - i_issue_has_rd and pending[rd]
  - Index 0 never stalls. There is no bypass: a writeback transfer in the current cycle does not lift the stall until pending clears.
- A writeback to a register that is not pending is legal; it writes and leaves pending at 0.

Test Plan:
- Reset then idle: o_rf_we=0, o_pending=0, both readys 0; assert rst low mid-transfer -> outputs return to 0 immediately.
- ALU alone writes rd=5, data=0xDEADBEEF -> o_alu_ready=1 same cycle; next cycle o_rf_we=1, waddr=5, wdata=0xDEADBEEF.
- ALU (rd=3) and LSU (rd=4) both valid for 2 cycles -> cycle0 LSU granted, cycle1 ALU granted; writes emitted in order 4 then 3; a third conflict grants LSU.
- Issue rd=7 accepted; next issue with rs1=7 -> stall held until the edge where o_rf_we=1 with waddr=7; stall drops the cycle after.
- Issue rd=9 accepted, then issue rd=9 again (WAW) -> stall until the writeback of 9; issue with rs1=0/rs2=0/rd=0 never stalls.
- LSU writeback with rd=0, data=0x1234 -> o_lsu_ready=1, o_rf_we stays 0, o_pending unchanged.
